pwm_start_sequencer: RTL and testbench

Start/stop sequencer for a bank of carrier generators. It enables the carriers one at a time with a programmable stagger, so switching edges are phase-distributed. On stop, it disables each carrier only at that carrier's next mask event, so no carrier halts mid-period. It sits between the AXI register file and the per-carrier `pwm_onoff` inputs.

---
 rtl/pwm_start_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pwm_start_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_start_sequencer.sv
// pwm_start_sequencer: staggered start and mask-aligned stop for a bank of
// carrier generators. Carriers are enabled one at a time, D cycles apart, in
// ascending index order. On stop, each carrier is released only at its own
// next mask event, so no carrier halts mid-period.
// Optional drain watchdog: define PWM_SEQ_DRAIN_TIMEOUT_EN to force-clear a
// drain that has not finished after TIMEOUT cycles (flagged in timeout_err).

module pwm_seq_lane (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    input  logic drain,
    input  logic maskevent,
    output logic onoff
);
    // One carrier enable: clear wins over set; while draining, a mask event releases it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   onoff <= 1'b0;
        else if (clr)                onoff <= 1'b0;
        else if (set)                onoff <= 1'b1;
        else if (drain && maskevent) onoff <= 1'b0;
    end
endmodule

module pwm_start_sequencer #(
    parameter int NCARR     = 8,
    parameter int DLY_WIDTH = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 abort,
    input  logic [NCARR-1:0]     chan_en,
    input  logic [DLY_WIDTH-1:0] delay,
    input  logic [NCARR-1:0]     maskevent,
    output logic [NCARR-1:0]     pwm_onoff,
    output logic [1:0]           seq_state,
    output logic                 busy,
    output logic                 running,
    output logic                 done,
    output logic                 timeout_err
);
    localparam int CW = DLY_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           state;
    logic [NCARR-1:0] pending;      // channels still waiting for their stagger slot
    logic [CW-1:0]    d_q;          // latched stagger, never below 1
    logic [CW-1:0]    cnt;          // cycles since the last channel was asserted
    logic [NCARR-1:0] start_low, start_rest, pend_low, pend_rest;
    logic [NCARR-1:0] set_vec, remain;
    logic             start_ok, stag_fire, drain_on, tmo_fire, clr_all;

    // Isolate the lowest set bit (two's-complement trick) for ascending order
    assign start_low  = chan_en & (~chan_en + NCARR'(1));
    assign start_rest = chan_en & ~start_low;
    assign pend_low   = pending & (~pending + NCARR'(1));
    assign pend_rest  = pending & ~pend_low;

    // stop outranks start, so a simultaneous stop suppresses the start in IDLE
    assign start_ok  = (state == IDLE) && start && !stop && !abort;
    assign stag_fire = (state == STAGGER) && !stop && !abort && (cnt == d_q);
    assign set_vec   = (start_ok && chan_en != '0) ? start_low :
                       stag_fire                   ? pend_low  : '0;
    assign drain_on  = (state == DRAIN);
    assign remain    = pwm_onoff & ~maskevent;
    assign clr_all   = abort | tmo_fire;

    assign seq_state = state;
    assign busy      = (state != IDLE);
    assign running   = (state == RUN);

    for (genvar i = 0; i < NCARR; i++) begin : g_lane
        pwm_seq_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .set       (set_vec[i]),
            .clr       (clr_all),
            .drain     (drain_on),
            .maskevent (maskevent[i]),
            .onoff     (pwm_onoff[i])
        );
    end

`ifdef PWM_SEQ_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 2);
    logic [TW-1:0] tcnt;

    assign tmo_fire = drain_on && !abort && (remain != '0) && (tcnt == TW'(TIMEOUT));

    // Drain watchdog: counts from 0 on DRAIN entry; error is sticky until the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!drain_on)                 tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
            if (start_ok)                  timeout_err <= 1'b0;
            else if (tmo_fire)             timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Sequencer FSM: abort > stop > start; done is a registered one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            d_q     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                pending <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            if (chan_en == '0) begin
                                done <= 1'b1;
                            end else begin
                                pending <= start_rest;
                                d_q     <= (delay == '0) ? CW'(1) : {1'b0, delay};
                                cnt     <= CW'(1);
                                state   <= (start_rest == '0) ? RUN : STAGGER;
                            end
                        end
                    end
                    STAGGER: begin
                        if (stop) begin
                            state   <= DRAIN;
                            pending <= '0;
                        end else if (cnt == d_q) begin
                            pending <= pend_rest;
                            cnt     <= CW'(1);
                            if (pend_rest == '0) state <= RUN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        if (stop) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (remain == '0 || tmo_fire) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_start_sequencer.sv
// Testbench for pwm_start_sequencer: table-driven vectors, hand sequences for
// multi-cycle corners, then randomized traffic against a schedule-based model.
// Build with PWM_SEQ_DRAIN_TIMEOUT_EN defined to exercise the drain watchdog.

module tb_pwm_start_sequencer;
    localparam int NC  = 8;
    localparam int DW  = 16;
    localparam int TMO = 20;
`ifdef PWM_SEQ_DRAIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [NC-1:0] chan_en = '0, maskevent = '0;
    logic [DW-1:0] delay = '0;
    logic [NC-1:0] pwm_onoff;
    logic [1:0]    seq_state;
    logic          busy, running, done, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_start_sequencer #(.NCARR(NC), .DLY_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort),
        .chan_en(chan_en), .delay(delay), .maskevent(maskevent),
        .pwm_onoff(pwm_onoff), .seq_state(seq_state), .busy(busy),
        .running(running), .done(done), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: each enabled channel gets an absolute assert edge
    // (start edge + k*D); the state follows from which of those edges are past.
    int            cyc = 0;
    int            m_state = 0;
    logic [NC-1:0] m_on = '0;
    int            sched[NC];
    int            dstart = 0;
    logic          m_done = 1'b0, m_err = 1'b0;

    task automatic model_reset();
        m_state = 0; m_on = '0; m_done = 1'b0; m_err = 1'b0;
        for (int i = 0; i < NC; i++) sched[i] = -1;
    endtask

    task automatic model_edge();
        int d, k;
        bit fut;
        m_done = 1'b0;
        if (abort) begin
            m_on = '0;
            m_state = 0;
        end else begin
            case (m_state)
                0: if (start && !stop) begin
                    m_err = 1'b0;
                    if (chan_en == '0) m_done = 1'b1;
                    else begin
                        d = (delay == '0) ? 1 : int'(delay);
                        k = 0;
                        for (int i = 0; i < NC; i++)
                            if (chan_en[i]) begin sched[i] = cyc + k * d; k++; end
                        m_state = 1;
                    end
                end
                1, 2: if (stop) begin
                    for (int i = 0; i < NC; i++) if (sched[i] >= cyc) sched[i] = -1;
                    m_state = 3;
                    dstart = cyc;
                end
                default: begin
                    m_on = m_on & ~maskevent;
                    if (m_on == '0) begin
                        m_state = 0; m_done = 1'b1;
                    end else if (TMO_EN && (cyc - dstart == TMO + 1)) begin
                        m_on = '0; m_err = 1'b1; m_done = 1'b1; m_state = 0;
                    end
                end
            endcase
            if (m_state == 1 || m_state == 2) begin
                fut = 1'b0;
                for (int i = 0; i < NC; i++) begin
                    if (sched[i] == cyc) m_on[i] = 1'b1;
                    if (sched[i] > cyc) fut = 1'b1;
                end
                m_state = fut ? 1 : 2;
            end
        end
        if (m_state == 0) for (int i = 0; i < NC; i++) sched[i] = -1;
        cyc++;
    endtask

    // Apply inputs, let the DUT sample them, then settle 1 ns past the edge
    task automatic step(input logic st, input logic sp, input logic ab,
                        input logic [NC-1:0] en, input logic [DW-1:0] dl,
                        input logic [NC-1:0] me);
        start = st; stop = sp; abort = ab; chan_en = en; delay = dl; maskevent = me;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(L, L, L, '0, '0, '0);
    endtask

    typedef struct {
        logic st, sp, ab;
        logic [NC-1:0] en;
        logic [DW-1:0] dl;
        logic [NC-1:0] me;
        logic [NC-1:0] x_on;
        logic [1:0]    x_st;
        logic          x_done;
    } vec_t;

    function automatic vec_t mkv(input logic st, input logic sp, input logic ab,
                                 input logic [NC-1:0] en, input logic [DW-1:0] dl,
                                 input logic [NC-1:0] me, input logic [NC-1:0] xon,
                                 input logic [1:0] xs, input logic xd);
        vec_t v;
        v.st = st; v.sp = sp; v.ab = ab; v.en = en; v.dl = dl; v.me = me;
        v.x_on = xon; v.x_st = xs; v.x_done = xd;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [NC-1:0] en_r, me_r;
        logic [DW-1:0] dl_r;
        int r;

        // stagger 8'hA5 / D=3, then drain, empty start, single channel, D=1, abort priority
        tbl.push_back(mkv(H, L, L, 8'hA5, 16'd3, 8'h00, 8'h01, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h01, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h01, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h05, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h05, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h05, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h25, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h25, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h25, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'hA5, 2'd2, L));
        tbl.push_back(mkv(H, L, L, 8'hFF, 16'd0, 8'h00, 8'hA5, 2'd2, L)); // start ignored in RUN
        tbl.push_back(mkv(L, H, L, 8'h00, 16'd0, 8'hA5, 8'hA5, 2'd3, L)); // stop-cycle maskevent ignored
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h01, 8'hA4, 2'd3, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h02, 8'hA4, 2'd3, L)); // clear bit: ignored
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'hA4, 8'h00, 2'd0, H));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h00, 2'd0, L));
        tbl.push_back(mkv(L, H, L, 8'h00, 16'd0, 8'h00, 8'h00, 2'd0, L)); // stop in IDLE
        tbl.push_back(mkv(H, L, L, 8'h00, 16'd5, 8'h00, 8'h00, 2'd0, H)); // empty start
        tbl.push_back(mkv(H, L, L, 8'h01, 16'd0, 8'h00, 8'h01, 2'd2, L));
        tbl.push_back(mkv(L, L, H, 8'h00, 16'd0, 8'h00, 8'h00, 2'd0, L));
        tbl.push_back(mkv(H, L, L, 8'h03, 16'd0, 8'h00, 8'h01, 2'd1, L));
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h03, 2'd2, L));
        tbl.push_back(mkv(H, H, H, 8'hFF, 16'd1, 8'h00, 8'h00, 2'd0, L)); // abort wins
        tbl.push_back(mkv(L, L, L, 8'h00, 16'd0, 8'h00, 8'h00, 2'd0, L));

        model_reset();
        #3;
        chk("rst_onoff", 32'(pwm_onoff), 32'h0);
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].ab, tbl[i].en, tbl[i].dl, tbl[i].me);
            chk($sformatf("tbl%0d_onoff", i), 32'(pwm_onoff), 32'(tbl[i].x_on));
            chk($sformatf("tbl%0d_state", i), 32'(seq_state), 32'(tbl[i].x_st));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].x_done));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].x_st != 2'd0));
            chk($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].x_st == 2'd2));
        end

        // graceful stop from RUN with all channels
        step(H, L, L, 8'hFF, 16'd1, 8'h00);
        idle(7);
        chk("gs_run_onoff", 32'(pwm_onoff), 32'hFF);
        chk("gs_run_state", 32'(seq_state), 32'd2);
        step(L, H, L, '0, '0, 8'h00);                   // S
        chk("gs_stop_state", 32'(seq_state), 32'd3);
        chk("gs_stop_onoff", 32'(pwm_onoff), 32'hFF);
        idle(1);                                        // S+1
        step(L, L, L, '0, '0, 8'h08);                   // S+2
        chk("gs_bit3_low", 32'(pwm_onoff), 32'hF7);
        idle(2);                                        // S+3, S+4
        chk("gs_hold_state", 32'(seq_state), 32'd3);
        chk("gs_hold_done", 32'(done), 32'd0);
        step(L, L, L, '0, '0, 8'hF7);                   // S+5
        chk("gs_final_onoff", 32'(pwm_onoff), 32'h00);
        chk("gs_final_done", 32'(done), 32'd1);
        chk("gs_final_state", 32'(seq_state), 32'd0);
        idle(1);
        chk("gs_done_pulse", 32'(done), 32'd0);

        // stop during STAGGER: D=10, stop 5 cycles after start, later channels never rise
        step(H, L, L, 8'h0F, 16'd10, 8'h00);
        idle(4);
        step(L, H, L, '0, '0, 8'h00);
        chk("ss_state", 32'(seq_state), 32'd3);
        idle(20);
        chk("ss_no_late_bits", 32'(pwm_onoff), 32'h01);
        step(L, L, L, '0, '0, 8'h02);
        chk("ss_clear_bit_ignored", 32'(pwm_onoff), 32'h01);
        step(L, L, L, '0, '0, 8'h03);
        chk("ss_drain_onoff", 32'(pwm_onoff), 32'h00);
        chk("ss_drain_done", 32'(done), 32'd1);

        // abort during DRAIN
        step(H, L, L, 8'h03, 16'd0, 8'h00);
        idle(1);
        step(L, H, L, '0, '0, 8'h00);
        step(L, L, H, '0, '0, 8'h00);
        chk("ab_onoff", 32'(pwm_onoff), 32'h00);
        chk("ab_state", 32'(seq_state), 32'd0);
        chk("ab_done", 32'(done), 32'd0);

        // drain timeout (or indefinite wait when the watchdog is not built)
        step(H, L, L, 8'h01, 16'd0, 8'h00);
        step(L, H, L, '0, '0, 8'h00);                   // DRAIN entry after this edge
`ifdef PWM_SEQ_DRAIN_TIMEOUT_EN
        idle(TMO);
        chk("to_before_state", 32'(seq_state), 32'd3);
        chk("to_before_onoff", 32'(pwm_onoff), 32'h01);
        chk("to_before_err", 32'(timeout_err), 32'd0);
        idle(1);
        chk("to_onoff", 32'(pwm_onoff), 32'h00);
        chk("to_state", 32'(seq_state), 32'd0);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        idle(2);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        step(L, L, H, '0, '0, 8'h00);
        chk("to_err_abort_keeps", 32'(timeout_err), 32'd1);
        step(H, L, L, 8'h01, 16'd0, 8'h00);
        chk("to_err_cleared", 32'(timeout_err), 32'd0);
        step(L, L, H, '0, '0, 8'h00);
`else
        idle(TMO + 10);
        chk("nt_state", 32'(seq_state), 32'd3);
        chk("nt_onoff", 32'(pwm_onoff), 32'h01);
        chk("nt_err", 32'(timeout_err), 32'd0);
        step(L, L, H, '0, '0, 8'h00);
`endif

        // asynchronous reset mid-stagger
        step(H, L, L, 8'hFF, 16'd1, 8'h00);
        idle(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_onoff", 32'(pwm_onoff), 32'h00);
        chk("arst_state", 32'(seq_state), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // randomized traffic against the model
        start = 1'b0; stop = 1'b0; abort = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r    = $urandom_range(0, 99);
            en_r = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
            dl_r = DW'($urandom_range(0, 4));
            me_r = NC'($urandom & $urandom);
            step(r < 10, r >= 10 && r < 14, r >= 14 && r < 16, en_r, dl_r, me_r);
            chk("rnd_onoff", 32'(pwm_onoff), 32'(m_on));
            chk("rnd_state", 32'(seq_state), 32'(m_state));
            chk("rnd_busy", 32'(busy), 32'(m_state != 0));
            chk("rnd_running", 32'(running), 32'(m_state == 2));
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_terr", 32'(timeout_err), 32'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
